// File: rtl/isp_awb_grayworld_pkg.sv
// Shared definitions for the gray-world AWB stage: default widths, gain constants
// and the gain-computation FSM state encoding.
package isp_awb_grayworld_pkg;

    localparam int AWB_DATA_W    = 8;
    localparam int AWB_SUM_W     = 32;
    localparam int AWB_GAIN_FRAC = 8;
    localparam int AWB_GAIN_W    = 12;

    localparam logic [AWB_GAIN_W-1:0] AWB_GAIN_MAX   = 12'hFFF;
    localparam logic [AWB_GAIN_W-1:0] AWB_UNITY_GAIN = 12'h100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIV_R  = 2'd1,
        DIV_B  = 2'd2,
        UPDATE = 2'd3
    } awb_state_e;

endpackage

// File: rtl/awb_serial_div.sv
// Restoring serial divider, one quotient bit per cycle. start loads the operands;
// done pulses one cycle after the last quotient bit is produced.
module awb_serial_div #(
    parameter int DVD_W = 40,
    parameter int DVS_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DVD_W + 1);

    logic [DVS_W-1:0] rem;
    logic [DVS_W-1:0] dvs;
    logic [CNT_W-1:0] cnt;
    logic [DVS_W+1:0] diff;

    // Quotient register doubles as the dividend shifter: its MSB feeds the remainder.
    assign diff = {1'b0, rem, quotient[DVD_W-1]} - {2'b00, dvs};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem      <= '0;
                dvs      <= divisor;
                quotient <= dividend;
                cnt      <= CNT_W'(DVD_W);
                busy     <= 1'b1;
            end else if (busy) begin
                if (!diff[DVS_W+1]) begin
                    rem      <= diff[DVS_W-1:0];
                    quotient <= {quotient[DVD_W-2:0], 1'b1};
                end else begin
                    rem      <= {rem[DVS_W-2:0], quotient[DVD_W-1]};
                    quotient <= {quotient[DVD_W-2:0], 1'b0};
                end
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/isp_awb_grayworld.sv
// Gray-world auto white balance: per-frame channel sums, R/B gains relative to G
// computed in vertical blanking, applied to the next frame via a 3-stage pipeline.
import isp_awb_grayworld_pkg::*;

module isp_awb_grayworld #(
    parameter int                 DATA_W    = AWB_DATA_W,
    parameter int                 SUM_W     = AWB_SUM_W,
    parameter int                 GAIN_FRAC = AWB_GAIN_FRAC,
    parameter int                 GAIN_W    = AWB_GAIN_W,
    parameter logic [GAIN_W-1:0]  GAIN_MAX  = AWB_GAIN_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              pre_vsync,
    input  logic              pre_de,
    input  logic [DATA_W-1:0] pre_r,
    input  logic [DATA_W-1:0] pre_g,
    input  logic [DATA_W-1:0] pre_b,
    output logic              post_vsync,
    output logic              post_de,
    output logic [DATA_W-1:0] post_r,
    output logic [DATA_W-1:0] post_g,
    output logic [DATA_W-1:0] post_b,
    output logic [GAIN_W-1:0] gain_r,
    output logic [GAIN_W-1:0] gain_b,
    output logic              stat_valid
);

    localparam int Q_W    = SUM_W + GAIN_FRAC;
    localparam int PROD_W = DATA_W + GAIN_W;
    localparam int RND_W  = PROD_W + 1;
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1) << GAIN_FRAC;

    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + (SUM_W+1)'(b);
        return s[SUM_W] ? '1 : s[SUM_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] round_sat(input logic [PROD_W-1:0] p);
        logic [RND_W-1:0] s;
        s = ({1'b0, p} + (RND_W'(1) << (GAIN_FRAC - 1))) >> GAIN_FRAC;
        return (s > RND_W'({DATA_W{1'b1}})) ? '1 : s[DATA_W-1:0];
    endfunction

    awb_state_e state, state_nxt;

    logic             vs_d, vs_rise, vs_fall;
    logic [SUM_W-1:0] acc_r, acc_g, acc_b;
    logic [SUM_W-1:0] snap_r, snap_g, snap_b;
    logic [GAIN_W-1:0] pend_r, pend_b;

    logic             div_start, div_busy, div_done;
    logic [Q_W-1:0]   div_dividend, div_q;
    logic [SUM_W-1:0] div_divisor;
    logic [GAIN_W-1:0] q_sat;

    assign vs_rise = pre_vsync & ~vs_d;
    assign vs_fall = ~pre_vsync & vs_d;

    // Statistics: a busy FSM at the vsync edge drops the frame but still clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d   <= 1'b0;
            acc_r  <= '0;
            acc_g  <= '0;
            acc_b  <= '0;
            snap_r <= '0;
            snap_g <= '0;
            snap_b <= '0;
        end else begin
            vs_d <= pre_vsync;
            if (vs_rise) begin
                acc_r <= '0;
                acc_g <= '0;
                acc_b <= '0;
                if (state == IDLE) begin
                    snap_r <= acc_r;
                    snap_g <= acc_g;
                    snap_b <= acc_b;
                end
            end else if (pre_de && !pre_vsync) begin
                acc_r <= sat_add(acc_r, pre_r);
                acc_g <= sat_add(acc_g, pre_g);
                acc_b <= sat_add(acc_b, pre_b);
            end
        end
    end

    // R division starts in the same cycle the snapshot is taken, so it reads acc_* directly.
    assign div_dividend = (state == IDLE) ? {acc_g,  {GAIN_FRAC{1'b0}}}
                                          : {snap_g, {GAIN_FRAC{1'b0}}};
    assign div_divisor  = (state == IDLE) ? acc_r : snap_b;
    assign q_sat        = (div_q > Q_W'(GAIN_MAX)) ? GAIN_MAX : div_q[GAIN_W-1:0];

    awb_serial_div #(
        .DVD_W (Q_W),
        .DVS_W (SUM_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        case (state)
            IDLE: begin
                if (vs_rise && !div_busy) begin
                    div_start = 1'b1;
                    state_nxt = DIV_R;
                end
            end
            DIV_R: begin
                if (div_done) begin
                    div_start = 1'b1;
                    state_nxt = DIV_B;
                end
            end
            DIV_B:   if (div_done) state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign stat_valid = (state == UPDATE);

    // A zero channel sum leaves that pending gain untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r <= UNITY;
            pend_b <= UNITY;
            gain_r <= UNITY;
            gain_b <= UNITY;
        end else begin
            if (state == DIV_R && div_done && snap_r != '0) pend_r <= q_sat;
            if (state == DIV_B && div_done && snap_b != '0) pend_b <= q_sat;
            if (vs_fall && state == IDLE) begin
                gain_r <= pend_r;
                gain_b <= pend_b;
            end
        end
    end

    logic [1:0]        de_pipe, vs_pipe;
    logic              s1_en, s2_en;
    logic [DATA_W-1:0] s1_r, s1_g, s1_b, s2_r, s2_g, s2_b;
    logic [PROD_W-1:0] s2_prod_r, s2_prod_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_pipe    <= '0;
            vs_pipe    <= '0;
            s1_en      <= 1'b0;
            s1_r       <= '0;
            s1_g       <= '0;
            s1_b       <= '0;
            s2_en      <= 1'b0;
            s2_r       <= '0;
            s2_g       <= '0;
            s2_b       <= '0;
            s2_prod_r  <= '0;
            s2_prod_b  <= '0;
            post_de    <= 1'b0;
            post_vsync <= 1'b0;
            post_r     <= '0;
            post_g     <= '0;
            post_b     <= '0;
        end else begin
            de_pipe    <= {de_pipe[0], pre_de};
            vs_pipe    <= {vs_pipe[0], pre_vsync};
            post_de    <= de_pipe[1];
            post_vsync <= vs_pipe[1];
            s1_en      <= en;
            s1_r       <= pre_r;
            s1_g       <= pre_g;
            s1_b       <= pre_b;
            s2_en      <= s1_en;
            s2_r       <= s1_r;
            s2_g       <= s1_g;
            s2_b       <= s1_b;
            s2_prod_r  <= PROD_W'(s1_r) * PROD_W'(gain_r);
            s2_prod_b  <= PROD_W'(s1_b) * PROD_W'(gain_b);
            if (de_pipe[1]) begin
                post_r <= s2_en ? round_sat(s2_prod_r) : s2_r;
                post_g <= s2_g;
                post_b <= s2_en ? round_sat(s2_prod_b) : s2_b;
            end else begin
                post_r <= '0;
                post_g <= '0;
                post_b <= '0;
            end
        end
    end

endmodule
